booth_multiplier_seq: RTL and testbench
=======================================

// Module: booth_multiplier_seq
// PURPOSE
//  Sequential signed radix-2 Booth multiplier, one add/sub step per clock.
//  Sits upstream of the 8-bit adder/subtractor: drives its operands and mode every cycle.
//  Consumes its sum and overflow results to build the 16-bit product.
//  Converts operand pairs into a 2*WIDTH product over WIDTH cycles under a start/busy/done handshake.
// PARAMETERS
//  WIDTH   8   operand width. Matches the adder/subtractor datapath; only 8 is verified.
//  CNT_W   3   step-counter width, = $clog2(WIDTH).
// PORTS
//  clk           in   1        single clock, rising edge
//  rst_n         in   1        asynchronous, active-low reset
//  start         in   1        request; sampled only when busy=0
//  multiplicand  in   WIDTH    signed operand M, captured on accepted start
//  multiplier    in   WIDTH    signed operand Q, captured on accepted start
//  busy          out  1        high while a multiplication is in progress
//  done          out  1        one-cycle pulse: product valid
//  product       out  2*WIDTH  signed result; held until next accepted start completes
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE; busy=0, done=0, product=0; A, Q, Q_1 and the counter are cleared.
//   - Reset mid-RUN aborts the operation; no done pulse is produced.
//  State machine IDLE -> RUN -> DONE -> IDLE:
//   - IDLE/DONE with start=1: load M, Q; set A=0, Q_1=0, cnt=0; go to RUN; busy=1 next cycle.
//   - RUN: one Booth step per edge; cnt++.
//   - On the edge where cnt==WIDTH-1: write product={A',Q'}, go to DONE; busy=0, done=1 for exactly one cycle.
//   - DONE: return to IDLE on the next edge unless start=1, which is accepted as in IDLE (back-to-back).
//   - start while busy=1 is ignored; operand inputs are not sampled in RUN.
//  Latency:
//   - start accepted at edge k -> done high and product valid after edge k+WIDTH.
//   - Throughput: one result per WIDTH+1 cycles.
//  Booth step on {Q[0],Q_1}:
//   - 01: S=A+M (adder mode = ADD).
//   - 10: S=A-M (adder mode = SUB).
//   - 00/11: S=A; adder result unused; sign bit = A[WIDTH-1].
//   - For 01/10 the true sign is S[WIDTH-1] XOR overflow, because the 9-bit intermediate exceeds 8 bits.
//   - Arithmetic right shift: A'={sign, S[WIDTH-1:1]}, Q'={S[0], Q[WIDTH-1:1]}, Q_1'=Q[0].
//   - This sign correction is mandatory; it makes M=-128 and every other corner exact.
//  Arithmetic: all two's complement; product is exact for the full range; no saturation or overflow output.
//  The adder's carry_out is unused.
// STRUCTURE
//  Shared package:
//   - state enum {IDLE, RUN, DONE}.
//   - constants MODE_ADD, MODE_SUB: the adder/subtractor mode encoding, defined once there.
//   - constant WIDTH=8.
//  One sub-module: the team's existing 8-bit adder/subtractor, instantiated once (operands A, M, mode).
//  The rest stays in this module:
//   - FSM and step counter.
//   - A/Q/Q_1 shift registers.
//   - product and done registers.
// TESTING
//  1. M=2, Q=1, start one cycle -> done exactly 8 cycles later; product=16'd2; busy high 8 cycles.
//  2. M=15, Q=10 -> product=16'd150 (0x0096); then M=-10, Q=15 -> product=-150 (0xFF6A).
//  3. M=-128, Q=-128 -> 16384 (0x4000); M=-128, Q=127 -> -16256 (0xC080); M=127, Q=127 -> 16129 (0x3F01).
//  4. start held high continuously with changing operands:
//     - each result is correct for the operands present at its accepting edge;
//     - starts during busy are ignored;
//     - the done-cycle start is accepted, giving done every 9 cycles.
//  5. rst_n pulled low at cycle 4 of RUN (M=15, Q=10) -> busy, done, product go 0 immediately;
//     no done after release; a following start (M=3, Q=-3) yields -9 (0xFFF7).
//  6. M=0 or Q=0, and M=-1, Q=-1 -> product=0 and 1 respectively; product holds between operations.

Source files
------------

// File: rtl/booth_multiplier_seq_pkg.sv
// Purpose: shared types and constants for the sequential Booth multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package booth_multiplier_seq_pkg;

    // Operand width of the multiplier datapath and the adder/subtractor.
    localparam int WIDTH = 8;

    // Adder/subtractor mode encoding, shared by the multiplier and the adder.
    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/booth_multiplier_seq_if.sv
// Purpose: start/busy/done request bus between a client and the Booth multiplier.
// Latency: n/a (wiring only).
// Backpressure: client may only issue start while busy is low; starts during busy are dropped.
interface booth_multiplier_seq_if;
    import booth_multiplier_seq_pkg::*;

    logic                 start;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    // Client side: issues requests, observes status and result.
    modport master (
        output start, multiplicand, multiplier,
        input  busy, done, product
    );

    // Multiplier side.
    modport slave (
        input  start, multiplicand, multiplier,
        output busy, done, product
    );

endinterface

// File: rtl/booth_multiplier_seq_addsub.sv
// Purpose: combinational WIDTH-bit adder/subtractor with carry and signed overflow.
// Latency: 0 cycles (purely combinational).
// Backpressure: none.
module booth_multiplier_seq_addsub
    import booth_multiplier_seq_pkg::*;
#(
    parameter int WIDTH = booth_multiplier_seq_pkg::WIDTH
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             mode_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             ovf_o
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   full;

    // Subtraction is a + ~b + 1; overflow when both addends share a sign the result lacks.
    always_comb begin
        b_eff   = (mode_i == MODE_SUB) ? ~b_i : b_i;
        full    = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, (mode_i == MODE_SUB)};
        sum_o   = full[WIDTH-1:0];
        carry_o = full[WIDTH];
        ovf_o   = (a_i[WIDTH-1] == b_eff[WIDTH-1]) && (full[WIDTH-1] != a_i[WIDTH-1]);
    end

endmodule

// File: rtl/booth_multiplier_seq.sv
// Purpose: sequential signed radix-2 Booth multiplier, one add/sub step per clock.
// Latency: start accepted at edge k -> done pulse and product valid after edge k+WIDTH.
// Backpressure: busy high during RUN; start is ignored while busy, accepted in IDLE or DONE.
module booth_multiplier_seq
    import booth_multiplier_seq_pkg::*;
#(
    parameter int WIDTH = booth_multiplier_seq_pkg::WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    booth_multiplier_seq_if.slave mul_if
);

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic                 q1_q, q1_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic                 load;
    logic                 step;
    logic                 last;

    logic                 add_mode;
    logic [WIDTH-1:0]     add_sum;
    logic                 add_ovf;
    logic                 carry_unused;

    logic [WIDTH-1:0]     s_sel;
    logic                 s_sign;
    logic [WIDTH-1:0]     a_step;
    logic [WIDTH-1:0]     q_step;

    // Pair 10 subtracts M; pair 01 (and the don't-care pairs) use add.
    assign add_mode = (q_q[0] & ~q1_q) ? MODE_SUB : MODE_ADD;

    booth_multiplier_seq_addsub #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .a_i     (a_q),
        .b_i     (m_q),
        .mode_i  (add_mode),
        .sum_o   (add_sum),
        .carry_o (carry_unused),
        .ovf_o   (add_ovf)
    );

    // One Booth step: pick A or A+/-M, recover its true sign, then arithmetic-shift {A,Q} right.
    always_comb begin
        s_sel  = a_q;
        s_sign = a_q[WIDTH-1];
        if (q_q[0] != q1_q) begin
            s_sel  = add_sum;
            // The true result needs WIDTH+1 bits; its sign is the sum MSB corrected by overflow.
            s_sign = add_sum[WIDTH-1] ^ add_ovf;
        end
        a_step = {s_sign, s_sel[WIDTH-1:1]};
        q_step = {s_sel[0], q_q[WIDTH-1:1]};
    end

    // Controller: accept start in IDLE/DONE, step through RUN, flag the final step.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        last    = 1'b0;
        case (state_q)
            IDLE: begin
                if (mul_if.start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    last    = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (mul_if.start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath next-state: load operands on accept, shift on each step, latch product on the last.
    always_comb begin
        m_d       = m_q;
        a_d       = a_q;
        q_d       = q_q;
        q1_d      = q1_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        if (load) begin
            m_d   = mul_if.multiplicand;
            a_d   = '0;
            q_d   = mul_if.multiplier;
            q1_d  = 1'b0;
            cnt_d = '0;
        end else if (step) begin
            a_d   = a_step;
            q_d   = q_step;
            q1_d  = q_q[0];
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (last) begin
            product_d = {a_step, q_step};
        end
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            m_q       <= '0;
            a_q       <= '0;
            q_q       <= '0;
            q1_q      <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            a_q       <= a_d;
            q_q       <= q_d;
            q1_q      <= q1_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign mul_if.busy    = (state_q == RUN);
    assign mul_if.done    = (state_q == DONE);
    assign mul_if.product = product_q;

endmodule

// File: tb/tb_booth_multiplier_seq.sv
// Purpose: self-checking bench for booth_multiplier_seq against an integer-multiply model.
// Latency: n/a.
// Backpressure: n/a.
module tb_booth_multiplier_seq;
    import booth_multiplier_seq_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   err_cnt = 0;
    int   chk_cnt = 0;

    booth_multiplier_seq_if mul_if ();

    booth_multiplier_seq dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .mul_if (mul_if)
    );

    always #5 clk = ~clk;

    // Reference: exact signed product truncated to 2*WIDTH bits.
    function automatic logic [2*WIDTH-1:0] ref_mul(input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] q);
        int p;
        p = int'($signed(m)) * int'($signed(q));
        return p[2*WIDTH-1:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one request from idle and check latency, busy span, result, pulse width and hold.
    task automatic run_op(input string tag, input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] q);
        int n;
        int bn;
        logic [2*WIDTH-1:0] exp;
        exp = ref_mul(m, q);
        mul_if.start        = 1'b1;
        mul_if.multiplicand = m;
        mul_if.multiplier   = q;
        @(posedge clk); #1;
        mul_if.start        = 1'b0;
        mul_if.multiplicand = WIDTH'($urandom);
        mul_if.multiplier   = WIDTH'($urandom);
        n  = 0;
        bn = 0;
        while (!mul_if.done && n < 30) begin
            if (mul_if.busy) bn++;
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_lat"},   32'(n),  32'(WIDTH));
        check({tag, "_busy"},  32'(bn), 32'(WIDTH));
        check({tag, "_prod"},  32'(mul_if.product), 32'(exp));
        @(posedge clk); #1;
        check({tag, "_pulse"}, 32'(mul_if.done), 32'd0);
        check({tag, "_hold"},  32'(mul_if.product), 32'(exp));
    endtask

    int                 rem;
    logic               exp_done;
    logic               seen;
    logic [2*WIDTH-1:0] expq[$];
    logic [2*WIDTH-1:0] e;
    logic [WIDTH-1:0]   rm, rq;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n               = 1'b0;
        mul_if.start        = 1'b0;
        mul_if.multiplicand = '0;
        mul_if.multiplier   = '0;
        #12;
        check("rst_busy", 32'(mul_if.busy), 32'd0);
        check("rst_done", 32'(mul_if.done), 32'd0);
        check("rst_prod", 32'(mul_if.product), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases.
        run_op("t1_2x1",       8'd2,    8'd1);
        run_op("t2_15x10",     8'd15,   8'd10);
        run_op("t2_m10x15",    8'hF6,   8'd15);
        run_op("t3_m128xm128", 8'h80,   8'h80);
        run_op("t3_m128x127",  8'h80,   8'h7F);
        run_op("t3_127x127",   8'h7F,   8'h7F);
        run_op("t6_0xq",       8'd0,    8'h5A);
        run_op("t6_mx0",       8'hA5,   8'd0);
        run_op("t6_m1xm1",     8'hFF,   8'hFF);
        repeat (5) @(posedge clk);
        #1;
        check("t6_idle_hold", 32'(mul_if.product), 32'd1);

        // Randomized single operations.
        for (int i = 0; i < 24; i++) begin
            run_op("rand", WIDTH'($urandom), WIDTH'($urandom));
        end

        // start held high with operands changing every cycle.
        rem          = 0;
        mul_if.start = 1'b1;
        for (int c = 0; c < 4 * (WIDTH + 1); c++) begin
            rm = WIDTH'($urandom);
            rq = WIDTH'($urandom);
            mul_if.multiplicand = rm;
            mul_if.multiplier   = rq;
            @(posedge clk);
            exp_done = 1'b0;
            if (rem > 0) begin
                rem--;
                if (rem == 0) exp_done = 1'b1;
            end else begin
                expq.push_back(ref_mul(rm, rq));
                rem = WIDTH;
            end
            #1;
            check("b2b_done", 32'(mul_if.done), 32'(exp_done));
            if (exp_done && expq.size() > 0) begin
                e = expq.pop_front();
                check("b2b_prod", 32'(mul_if.product), 32'(e));
            end
        end
        mul_if.start = 1'b0;
        @(posedge clk); #1;
        check("b2b_idle", 32'(mul_if.busy | mul_if.done), 32'd0);

        // Reset in the middle of RUN.
        mul_if.start        = 1'b1;
        mul_if.multiplicand = 8'd15;
        mul_if.multiplier   = 8'd10;
        @(posedge clk); #1;
        mul_if.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mid_busy_pre", 32'(mul_if.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", 32'(mul_if.busy), 32'd0);
        check("rst_mid_done", 32'(mul_if.done), 32'd0);
        check("rst_mid_prod", 32'(mul_if.product), 32'd0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            seen = seen | mul_if.done | mul_if.busy;
        end
        check("rst_no_done", 32'(seen), 32'd0);
        run_op("t5_3xm3", 8'd3, 8'hFD);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
